// File: rtl/div_seq.sv
// Sequential restoring divider, one quotient bit per clock, with signed/unsigned modes,
// abort, divide-by-zero detection and a one-cycle done pulse.
//
// state | meaning
// IDLE  | waiting for init; handles divide-by-zero in place
// LOAD  | operands converted to magnitudes, signs recorded, counter armed
// CALC  | one restoring step per cycle, WIDTH cycles total
// FIX   | signs applied, hi/lo written, done pulsed
module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init,
    input  logic             stop,
    input  logic             sgn,
    input  logic [WIDTH-1:0] n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             divzero,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, LOAD, CALC, FIX} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             sgn_q, sgn_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             divzero_q, divzero_d;
    logic             done_q, done_d;
    logic [WIDTH:0]   rem_sh;
    logic             ge;

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        d_d       = d_q;
        sgn_d     = sgn_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        cnt_d     = cnt_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        divzero_d = divzero_q;
        done_d    = 1'b0;
        rem_sh    = '0;
        ge        = 1'b0;

        if (stop) begin
            state_d   = IDLE;
            hi_d      = '0;
            lo_d      = '0;
            divzero_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (init) begin
                        if (d == '0) begin
                            divzero_d = 1'b1;
                            hi_d      = '0;
                            lo_d      = '0;
                            done_d    = 1'b1;
                        end else begin
                            n_d       = n;
                            d_d       = d;
                            sgn_d     = sgn;
                            divzero_d = 1'b0;
                            state_d   = LOAD;
                        end
                    end
                end
                LOAD: begin
                    n_d     = (sgn_q && n_q[WIDTH-1]) ? -n_q : n_q;
                    d_d     = (sgn_q && d_q[WIDTH-1]) ? -d_q : d_q;
                    qneg_d  = sgn_q & (n_q[WIDTH-1] ^ d_q[WIDTH-1]);
                    rneg_d  = sgn_q & n_q[WIDTH-1];
                    rem_d   = '0;
                    quo_d   = '0;
                    cnt_d   = CW'(WIDTH);
                    state_d = CALC;
                end
                CALC: begin
                    // n_q doubles as the dividend shift register, MSB first
                    rem_sh = (rem_q << 1) | {{WIDTH{1'b0}}, n_q[WIDTH-1]};
                    ge     = (rem_sh >= {1'b0, d_q});
                    rem_d  = ge ? (rem_sh - {1'b0, d_q}) : rem_sh;
                    quo_d  = {quo_q[WIDTH-2:0], ge};
                    n_d    = n_q << 1;
                    cnt_d  = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d = FIX;
                    end
                end
                FIX: begin
                    lo_d    = qneg_q ? -quo_q : quo_q;
                    hi_d    = rneg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            n_q       <= '0;
            d_q       <= '0;
            sgn_q     <= 1'b0;
            rem_q     <= '0;
            quo_q     <= '0;
            cnt_q     <= '0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            divzero_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            d_q       <= d_d;
            sgn_q     <= sgn_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            cnt_q     <= cnt_d;
            qneg_q    <= qneg_d;
            rneg_q    <= rneg_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            divzero_q <= divzero_d;
            done_q    <= done_d;
        end
    end

    assign hi      = hi_q;
    assign lo      = lo_q;
    assign divzero = divzero_q;
    assign done    = done_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq at WIDTH=32: hand-computed results, latency,
// divide-by-zero, overflow, abort, reset mid-operation and re-init behaviour.
module tb_div_seq;

    logic        clk = 1'b0;
    logic        rst, init, stop, sgn;
    logic [31:0] n, d;
    logic [31:0] hi, lo;
    logic        divzero, busy, done;

    int checks = 0;
    int errors = 0;

    div_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .init(init), .stop(stop), .sgn(sgn),
        .n(n), .d(d), .hi(hi), .lo(lo),
        .divzero(divzero), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (done !== 1'b1 && cyc < 200);
    endtask

    task automatic start(input logic s, input logic [31:0] nn, input logic [31:0] dd);
        sgn = s; n = nn; d = dd; init = 1'b1;
        tick();
        init = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic s, input logic [31:0] nn,
                          input logic [31:0] dd, input logic [31:0] exp_lo,
                          input logic [31:0] exp_hi);
        int cyc;
        start(s, nn, dd);
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        wait_done(cyc);
        chk({tag, "_latency"}, 64'(cyc), 64'd34);
        chk({tag, "_lo"}, 64'(lo), 64'(exp_lo));
        chk({tag, "_hi"}, 64'(hi), 64'(exp_hi));
        chk({tag, "_divzero"}, 64'(divzero), 64'd0);
        tick();
        chk({tag, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        int cyc;
        int saw_done;
        rst = 1'b1; init = 1'b0; stop = 1'b0; sgn = 1'b0; n = '0; d = '0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_divzero", 64'(divzero), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);

        run_op("u100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
        run_op("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run_op("u_m7_2", 1'b0, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'h0000_0001);
        run_op("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);

        // divide by zero, with a nonzero previous result in hi/lo
        start(1'b0, 32'd5, 32'd0);
        chk("dz_flag", 64'(divzero), 64'd1);
        chk("dz_hi", 64'(hi), 64'd0);
        chk("dz_lo", 64'(lo), 64'd0);
        chk("dz_done", 64'(done), 64'd1);
        chk("dz_busy", 64'(busy), 64'd0);
        tick();
        chk("dz_hold", 64'(divzero), 64'd1);
        chk("dz_done_pulse", 64'(done), 64'd0);
        start(1'b0, 32'd9, 32'd3);
        chk("dz_clear", 64'(divzero), 64'd0);
        wait_done(cyc);
        chk("dz_next_lo", 64'(lo), 64'd3);
        tick();

        run_op("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
        run_op("u_max", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0);
        run_op("s_min_3", 1'b1, 32'h8000_0000, 32'd3, 32'hD555_5556, 32'hFFFF_FFFE);

        // abort by stop at cycle 10
        start(1'b0, 32'd100, 32'd7);
        repeat (9) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_busy", 64'(busy), 64'd0);
        chk("stop_hi", 64'(hi), 64'd0);
        chk("stop_lo", 64'(lo), 64'd0);
        chk("stop_done", 64'(done), 64'd0);
        saw_done = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done === 1'b1) saw_done++;
        end
        chk("stop_no_done", 64'(saw_done), 64'd0);

        // stop wins over a simultaneous init
        sgn = 1'b0; n = 32'd100; d = 32'd7; init = 1'b1; stop = 1'b1;
        tick();
        init = 1'b0; stop = 1'b0;
        chk("stop_init_busy", 64'(busy), 64'd0);

        // reset at cycle 20 of an operation, after a nonzero result
        run_op("pre_rst", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
        start(1'b0, 32'd100, 32'd7);
        repeat (19) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_hi", 64'(hi), 64'd0);
        chk("mrst_lo", 64'(lo), 64'd0);
        chk("mrst_done", 64'(done), 64'd0);
        saw_done = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done === 1'b1) saw_done++;
        end
        chk("mrst_no_done", 64'(saw_done), 64'd0);

        // init while busy is ignored
        start(1'b0, 32'd100, 32'd7);
        repeat (4) tick();
        n = 32'd9; d = 32'd3; init = 1'b1;
        tick();
        init = 1'b0;
        wait_done(cyc);
        chk("reinit_latency", 64'(cyc + 5), 64'd34);
        chk("reinit_lo", 64'(lo), 64'd14);
        chk("reinit_hi", 64'(hi), 64'd2);

        // init accepted in the done cycle
        start(1'b0, 32'd9, 32'd3);
        chk("done_init_busy", 64'(busy), 64'd1);
        wait_done(cyc);
        chk("done_init_latency", 64'(cyc), 64'd34);
        chk("done_init_lo", 64'(lo), 64'd3);
        chk("done_init_hi", 64'(hi), 64'd0);
        tick();
        chk("hold_lo", 64'(lo), 64'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
